// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment scanner.
//   DIGITS_DEFAULT  - default number of multiplexed digits
//   CLK_DIV_DEFAULT - default clock cycles per digit time slot
//   NIBBLE_W        - width of the hex code handed to the segment decoder
//   ANODE_OFF       - all-dark anode pattern (active-low), sliced to DIGITS
package seg_pkg;

    localparam int unsigned DIGITS_DEFAULT  = 8;
    localparam int unsigned CLK_DIV_DEFAULT = 50000;
    localparam int unsigned NIBBLE_W        = 4;
    localparam logic [7:0]  ANODE_OFF       = 8'hFF;

endpackage

// File: rtl/scan_tick.sv
// Slot-rate divider for the digit scanner.
//   clk   - clock, all state on rising edge
//   rst_n - asynchronous active-low reset, clears the counter
//   tick  - high for one cycle when the counter sits at CLK_DIV-1
module scan_tick #(
    parameter int unsigned CLK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] div_cnt_q;

    assign tick = (div_cnt_q == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else if (tick) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scanner.sv
// Time-multiplexed hex display scanner.
//   clk         - clock, all state on rising edge
//   rst_n       - asynchronous active-low reset
//   value       - hex value to show, nibble i -> digit i (digit 0 rightmost)
//   load        - one-cycle strobe capturing value
//   digit_en    - per-digit enable, 0 keeps that digit dark
//   blank_lz    - 1 suppresses leading zeros (digit 0 always shown)
//   nibble      - hex code of the active digit for the segment decoder
//   anode_n     - active-low digit select, at most one bit low
//   frame_start - one-cycle pulse the cycle after digit 0 becomes active
module seg_scanner
    import seg_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT,
    parameter int unsigned DIGITS  = DIGITS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  blank_lz,
    output logic [NIBBLE_W-1:0]   nibble,
    output logic [DIGITS-1:0]     anode_n,
    output logic                  frame_start
);

    localparam int unsigned IW = $clog2(DIGITS);
    localparam logic [DIGITS-1:0] OFF = ANODE_OFF[DIGITS-1:0];

    logic                tick;
    logic                last_slot;
    logic                wrap;
    logic                wrap_q;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [4*DIGITS-1:0] pending_q, pending_d;
    logic                pend_q, pend_d;
    logic                lz_zero;
    logic                blanked;
    logic [NIBBLE_W-1:0] nibble_d;
    logic [DIGITS-1:0]   anode_d;

    scan_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_scan_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign last_slot = (idx_q == IW'(DIGITS - 1));
    assign wrap      = tick && last_slot;

    always_comb begin
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        pend_d    = pend_q;

        if (tick) begin
            idx_d = last_slot ? '0 : idx_q + 1'b1;
        end

        // At a frame wrap a coinciding load bypasses pending straight into shadow.
        if (wrap) begin
            if (load) begin
                shadow_d = value;
            end else if (pend_q) begin
                shadow_d = pending_q;
            end
            pend_d = 1'b0;
        end else if (load) begin
            pending_d = value;
            pend_d    = 1'b1;
        end
    end

    // Leading-zero scan from the top digit down, evaluated on the value the
    // new slot will display so a wrap-time update is blanked correctly.
    always_comb begin
        lz_zero = 1'b1;
        blanked = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lz_zero = lz_zero && (shadow_d[4*i +: 4] == 4'h0);
            if (IW'(i) == idx_d) begin
                blanked = blank_lz && lz_zero;
            end
        end
    end

    always_comb begin
        nibble_d = shadow_d[{idx_d, 2'b00} +: NIBBLE_W];
        anode_d  = OFF;
        if (digit_en[idx_d] && !blanked) begin
            anode_d[idx_d] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= IW'(DIGITS - 1);
            shadow_q    <= '0;
            pending_q   <= '0;
            pend_q      <= 1'b0;
            wrap_q      <= 1'b0;
            nibble      <= '0;
            anode_n     <= OFF;
            frame_start <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            pend_q      <= pend_d;
            wrap_q      <= wrap;
            frame_start <= wrap_q;
            if (tick) begin
                nibble  <= nibble_d;
                anode_n <= anode_d;
            end
        end
    end

endmodule

// File: tb/tb_seg_scanner.sv
module tb_seg_scanner;

    localparam int CD = 4;
    localparam int DG = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] value = '0;
    logic        load = 1'b0;
    logic [7:0]  digit_en = 8'hFF;
    logic        blank_lz = 1'b0;
    logic [3:0]  nibble;
    logic [7:0]  anode_n;
    logic        frame_start;

    seg_scanner #(
        .CLK_DIV (CD),
        .DIGITS  (DG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value       (value),
        .load        (load),
        .digit_en    (digit_en),
        .blank_lz    (blank_lz),
        .nibble      (nibble),
        .anode_n     (anode_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] an;
        logic [3:0] nib;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: time measured in edges since reset release; slot s
    // starts at edge s*CD and shows digit (s-1) mod DG.
    int          n = 0;
    logic [31:0] disp = '0;
    logic [31:0] pv = '0;
    bit          pvalid = 0;
    bit          wrap_prev = 0;
    logic [7:0]  e_an = 8'hFF;
    logic [3:0]  e_nib = 4'h0;

    function automatic bit next_is_wrap();
        return ((n + 1) % CD == 0) && (((n + 1) / CD - 1) % DG == 0);
    endfunction

    function automatic void model_edge();
        exp_t x;
        int   e;
        int   idx;
        bit   lit;
        logic [31:0] upper;
        bit   fs;
        if (!rst_n) begin
            n = 0; disp = '0; pv = '0; pvalid = 0; wrap_prev = 0;
            e_an = 8'hFF; e_nib = 4'h0;
            x.an = 8'hFF; x.nib = 4'h0; x.fs = 1'b0;
            q.push_back(x);
            return;
        end
        e = n + 1;
        n = e;
        if (load) begin
            pv = value;
            pvalid = 1;
        end
        fs = wrap_prev;
        wrap_prev = 0;
        if (e % CD == 0) begin
            idx = (e / CD - 1) % DG;
            if (idx == 0) begin
                if (pvalid) disp = pv;
                pvalid = 0;
                wrap_prev = 1;
            end
            upper = disp >> (4 * idx);
            lit = digit_en[idx] && !(blank_lz && idx > 0 && upper == 32'h0);
            e_an = lit ? ~(8'h01 << idx) : 8'hFF;
            e_nib = upper[3:0];
        end
        x.an = e_an; x.nib = e_nib; x.fs = fs;
        q.push_back(x);
    endfunction

    task automatic step(input logic ld, input logic [31:0] v, input bit rel);
        @(negedge clk);
        if (rel) rst_n = 1'b1;
        load = ld;
        value = v;
        model_edge();
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, value, 1'b0);
    endtask

    task automatic run_to_wrap();
        for (int i = 0; i < 2 * CD * DG && !next_is_wrap(); i++) step(1'b0, value, 1'b0);
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({anode_n, nibble, frame_start} !== {8'hFF, 4'h0, 1'b0}) begin
            failures++;
            $display("FAIL async_reset got an=%h nib=%h fs=%b want an=ff nib=0 fs=0",
                     anode_n, nibble, frame_start);
        end
    endtask

    // Monitor: one expected tuple per edge, compared just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t x;
                x = q.pop_front();
                checks++;
                if ({anode_n, nibble, frame_start} !== x) begin
                    failures++;
                    $display("FAIL outputs t=%0t got an=%h nib=%h fs=%b want an=%h nib=%h fs=%b",
                             $time, anode_n, nibble, frame_start, x.an, x.nib, x.fs);
                end
            end
        end
    end

    initial begin
        logic [31:0] v;
        run(3);
        // Load on the first edge after release shows in the very first frame.
        step(1'b1, 32'h1234_5678, 1'b1);
        run(70);

        // Mid-frame load waits for the next frame.
        step(1'b1, 32'h1111_1111, 1'b0);
        run_to_wrap();
        run(12);
        step(1'b1, 32'hDEAD_BEEF, 1'b0);
        run(70);

        // Load exactly on the wrap edge, then two loads in one frame.
        run_to_wrap();
        step(1'b1, 32'hCAFE_0001, 1'b0);
        run(8);
        step(1'b1, 32'hAAAA_5555, 1'b0);
        run(5);
        step(1'b1, 32'h0BAD_F00D, 1'b0);
        run(70);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        step(1'b1, 32'h0000_00A0, 1'b0);
        run(70);
        step(1'b1, 32'h0000_0000, 1'b0);
        run(70);
        blank_lz = 1'b0;

        // Upper digits disabled; frame timing unchanged.
        step(1'b1, 32'h8765_4321, 1'b0);
        digit_en = 8'h0F;
        run(80);
        digit_en = 8'hFF;

        // Reset mid-slot with a load still pending.
        run(6);
        step(1'b1, 32'h9999_9999, 1'b0);
        run(3);
        async_reset();
        run(3);
        step(1'b0, value, 1'b1);
        run(70);

        // Randomized traffic.
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 49) == 0) digit_en = 8'($urandom);
            if ($urandom_range(0, 49) == 0) blank_lz = 1'($urandom);
            v = $urandom;
            if ($urandom_range(0, 2) == 0) v = v >> (4 * $urandom_range(1, 8));
            step(1'($urandom_range(0, 15) == 0), v, 1'b0);
        end

        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scanner.md
SEG_SCANNER -- requirements
Module: seg_scanner

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, clock cycles per digit time slot (>=2).
REQ-002 SHALL have parameter DIGITS, default 8, number of multiplexed digits (2..8).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port value  input  4*DIGITS  hex value to show, nibble i -> digit i, digit 0 rightmost.
REQ-006 SHALL have port load  input  1  one-cycle strobe capturing value.
REQ-007 SHALL have port digit_en  input  DIGITS  per-digit enable, 0 = digit dark.
REQ-008 SHALL have port blank_lz  input  1  1 = suppress leading zeros.
REQ-009 SHALL have port nibble  output  4  hex code for the active digit, fed to the 7-segment decoder.
REQ-010 SHALL have port anode_n  output  DIGITS  active-low digit select, at most one bit low.
REQ-011 SHALL have port frame_start  output  1  one-cycle pulse when digit 0 becomes active.

Function
REQ-012 SHALL count div_cnt 0..CLK_DIV-1 and wrap; tick asserted in the cycle div_cnt==CLK_DIV-1.
REQ-013 SHALL advance digit index idx on every tick: idx+1, or DIGITS-1 -> 0 (frame wrap).
REQ-014 SHALL register nibble and anode_n on the same edge idx advances, reflecting the new idx; no combinational path from inputs to outputs.
REQ-015 SHALL hold two registers: pending (value + pend flag) and shadow (displayed value).
REQ-016 SHALL on load capture value into pending and set pend; later load before wrap overwrites pending.
REQ-017 SHALL on frame wrap copy pending into shadow if pend set, clearing pend; otherwise shadow unchanged.
REQ-018 SHALL when load coincides with frame wrap copy the input value directly to shadow and leave pend clear.
REQ-019 SHALL drive nibble = shadow nibble idx for the active slot.
REQ-020 SHALL drive anode_n all ones for the slot when digit_en[idx]==0 or digit idx is blanked; otherwise only bit idx low.
REQ-021 SHALL treat digit idx as blanked when blank_lz==1, idx>0, and all shadow nibbles idx..DIGITS-1 are zero; digit 0 is never blanked.
REQ-022 SHALL pulse frame_start for exactly one cycle, the cycle after the edge where idx becomes 0.
REQ-023 SHALL sample digit_en and blank_lz at each tick; changes take effect from the next slot.
REQ-024 SHALL give every frame length exactly DIGITS*CLK_DIV cycles regardless of enables or blanking.

Reset
REQ-025 SHALL on rst_n low immediately set div_cnt=0, idx=DIGITS-1, shadow=0, pending=0, pend=0.
REQ-026 SHALL on rst_n low immediately drive anode_n all ones, nibble=0, frame_start=0.
REQ-027 SHALL make the first tick after reset release a frame wrap, so a load before it displays in the first frame.
REQ-028 SHALL discard any pending load when reset asserts mid-frame.

Structure
REQ-029 SHALL place DIGITS default, CLK_DIV default, nibble width and ANODE_OFF constant in shared package seg_pkg.
REQ-030 SHALL implement the divider as sub-module scan_tick (parameter CLK_DIV; ports clk, rst_n, tick).
REQ-031 SHALL compute blanking from shadow with a leading-zero scan, no extra state.

Verification (CLK_DIV=4, DIGITS=8)
REQ-032 SHALL check: reset release, load 0x12345678 at cycle 1 -> at cycle 4 anode_n=0xFE, nibble=8, frame_start at cycle 5; digit 7 shows 1, each slot 4 cycles.
REQ-033 SHALL check: blank_lz=1, value 0x000000A0 -> digits 0,1 lit (0,A), digits 2..7 anode_n=0xFF; value 0 -> only digit 0 lit showing 0.
REQ-034 SHALL check: load 0xDEADBEEF mid-frame while shadow=0x11111111 -> remaining slots show 1; next frame shows DEADBEEF from digit 0.
REQ-035 SHALL check: load coinciding with wrap tick -> new value on digit 0 same edge, pend stays 0; two loads in one frame -> only second shown.
REQ-036 SHALL check: digit_en=0x0F -> digits 4..7 anode_n=0xFF, frame still 32 cycles, frame_start period 32.
REQ-037 SHALL check: rst_n low mid-slot with pending load -> outputs all-off asynchronously; after release shadow=0, load discarded.
